// File: rtl/matrixmul_job_scheduler.sv
// Round-robin sharing of one ap_ctrl_hs matrixmul core between NUM_REQ requesters.
// Issues ap_start, tracks ap_ready/ap_done, and returns owner id plus saturating job latency.
module matrixmul_job_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               acc_ap_start,
  input  logic               acc_ap_ready,
  input  logic               acc_ap_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [CNT_W-1:0]   rsp_cycles,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  state_t            state, state_nx;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick;
  logic              pick_ok;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;

  // Search from last_grant+1 so the most recently served requester has lowest priority.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!pick_ok && req_valid[ID_W'((32'(last_grant) + k) % NUM_REQ)]) begin
        pick    = ID_W'((32'(last_grant) + k) % NUM_REQ);
        pick_ok = 1'b1;
      end
    end
  end

  assign req_ready = (state == S_IDLE && pick_ok) ? (NUM_REQ'(1) << pick) : '0;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (pick_ok) state_nx = S_START;
      // A done without ready still means the core has consumed its inputs.
      S_START: if (acc_ap_done) state_nx = S_RESP;
               else if (acc_ap_ready) state_nx = S_RUN;
      S_RUN:   if (acc_ap_done) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      last_grant   <= LAST_INIT;
      cnt          <= '0;
      rsp_id       <= '0;
      rsp_cycles   <= '0;
      acc_ap_start <= 1'b0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      acc_ap_start <= (state_nx == S_START);
      rsp_valid    <= (state_nx == S_RESP);
      busy         <= (state_nx != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (pick_ok) begin
            last_grant <= pick;
            cnt        <= '0;
          end
        end
        S_START, S_RUN: begin
          cnt <= cnt_inc;
          // last_grant doubles as the job owner until the next grant.
          if (state_nx == S_RESP) begin
            rsp_id     <= last_grant;
            rsp_cycles <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrixmul_job_scheduler.sv
// Scoreboard bench for matrixmul_job_scheduler: a core model with chosen latencies,
// a round-robin reference model, and a monitor comparing grants and responses.
`timescale 1ns/1ps
module tb_matrixmul_job_scheduler;

  localparam int N    = 3;
  localparam int IDW  = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic           acc_ap_start;
  logic           acc_ap_ready = 1'b0;
  logic           acc_ap_done = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0]  rsp_cycles;
  logic           busy;

  always #5 clk = ~clk;

  matrixmul_job_scheduler #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .acc_ap_start(acc_ap_start), .acc_ap_ready(acc_ap_ready), .acc_ap_done(acc_ap_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_cycles(rsp_cycles), .busy(busy)
  );

  typedef struct { int id; int cyc; } rsp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t exp_q[$];
  int   pend_q[$];
  int   grant_log[$];
  int   ref_last = N - 1;
  bit   model_idle = 1'b1;
  bit   rsp_due = 1'b0;
  bit   prev_grant = 1'b0;
  bit   was_injob;
  int   grant_cnt = 0;
  int   rsp_cnt = 0;
  int   last_rsp_id = -1;
  int   last_rsp_cyc = -1;
  int   m_g, m_idx, m_act;
  logic [N-1:0] m_exp_rr;

  bit   core_act = 1'b0;
  bit   core_killed = 1'b0;
  bit   use_fixed = 1'b0;
  int   fix_lr, fix_ld;
  int   age, lr, ld, c_id;

  function automatic void check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Core model: ap_ready at start+lr, ap_done at start+ld (ld < lr models the early-done case).
  always @(posedge clk) begin
    #2;
    if (core_act && age >= ld) begin
      core_act    = 1'b0;
      core_killed = 1'b0;
    end
    if (!core_act) begin
      acc_ap_ready = 1'b0;
      acc_ap_done  = 1'b0;
      if (rst_n && acc_ap_start) begin
        core_act = 1'b1;
        age      = 0;
        if (use_fixed) begin
          lr = fix_lr;
          ld = fix_ld;
        end else begin
          lr = $urandom_range(4, 1);
          case ($urandom_range(9, 0))
            0:       ld = $urandom_range(lr - 1, 0);
            1:       ld = lr;
            default: ld = lr + $urandom_range(20, 1);
          endcase
        end
        check("grant_before_start", int'(pend_q.size() > 0), 1);
        if (pend_q.size() > 0) begin
          c_id = pend_q.pop_front();
          exp_q.push_back('{c_id, (ld + 1 > MAXC) ? MAXC : ld + 1});
        end
      end
    end else begin
      age++;
    end
    if (core_act) begin
      if (!core_killed)
        check("ap_start_level", int'(acc_ap_start), int'(age <= ((lr < ld) ? lr : ld)));
      acc_ap_ready = (age == lr);
      acc_ap_done  = (age == ld);
    end
  end

  // Monitor: reference arbitration and response scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = 1'b0;
    end else begin
      was_injob = !model_idle && !rsp_due;
      m_g = -1;
      if (model_idle) begin
        for (int k = 1; k <= N; k++) begin
          m_idx = (ref_last + k) % N;
          if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
        end
      end
      m_exp_rr = (m_g >= 0) ? (N'(1) << m_g) : '0;
      check("req_ready", int'(req_ready), int'(m_exp_rr));
      check("busy", int'(busy), int'(!model_idle));
      check("rsp_valid", int'(rsp_valid), int'(rsp_due));
      if (prev_grant) check("start_after_grant", int'(acc_ap_start), 1);
      prev_grant = (m_g >= 0);
      if (m_g >= 0) begin
        m_act = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) m_act = i;
        grant_log.push_back(m_act);
        ref_last   = m_g;
        pend_q.push_back(m_g);
        model_idle = 1'b0;
        grant_cnt++;
      end
      if (rsp_valid) begin
        check("rsp_has_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("rsp_id", int'(rsp_id), exp_q[0].id);
          check("rsp_cycles", int'(rsp_cycles), exp_q[0].cyc);
          if (rsp_ready) begin
            last_rsp_id  = int'(rsp_id);
            last_rsp_cyc = int'(rsp_cycles);
            void'(exp_q.pop_front());
            rsp_cnt++;
            rsp_due    = 1'b0;
            model_idle = 1'b1;
          end
        end
      end
      if (acc_ap_done && was_injob) rsp_due = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int g0, input string nm);
    int i = 0;
    while (grant_cnt == g0 && i < 300) begin tick(); i++; end
    check(nm, int'(grant_cnt > g0), 1);
  endtask

  task automatic wait_rsp(input int target, input string nm);
    int i = 0;
    while (rsp_cnt < target && i < 500) begin tick(); i++; end
    check(nm, int'(rsp_cnt >= target), 1);
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    while (!(model_idle && !core_act && exp_q.size() == 0 && pend_q.size() == 0) && i < 500) begin
      tick(); i++;
    end
    check(nm, int'(model_idle && !core_act && exp_q.size() == 0), 1);
  endtask

  task automatic one_job(input logic [N-1:0] rv, input int l_r, input int l_d);
    int g0, r0;
    use_fixed = 1'b1; fix_lr = l_r; fix_ld = l_d;
    g0 = grant_cnt; r0 = rsp_cnt;
    req_valid = rv;
    wait_grant(g0, "grant_timeout");
    req_valid = '0;
    wait_rsp(r0 + 1, "rsp_timeout");
    wait_idle("idle_timeout");
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, int'(req_ready), 0);
    check({nm, "_start"}, int'(acc_ap_start), 0);
    check({nm, "_rsp_valid"}, int'(rsp_valid), 0);
    check({nm, "_rsp_id"}, int'(rsp_id), 0);
    check({nm, "_rsp_cycles"}, int'(rsp_cycles), 0);
    check({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int g0, r0, i;
    #3;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single job: ready at +1, done at +5.
    rsp_ready = 1'b1;
    one_job(3'b001, 1, 5);
    check("single_id", last_rsp_id, 0);
    check("single_cycles", last_rsp_cyc, 6);

    // Same-cycle ready and done at +3.
    one_job(3'b001, 3, 3);
    check("sameready_cycles", last_rsp_cyc, 4);

    // Saturation: done at +40 with a 4-bit counter.
    one_job(3'b010, 1, 40);
    check("sat_id", last_rsp_id, 1);
    check("sat_cycles", last_rsp_cyc, MAXC);

    // Fairness with two requesters held high.
    grant_log.delete();
    use_fixed = 1'b1; fix_lr = 2; fix_ld = 3;
    r0 = rsp_cnt;
    req_valid = 3'b011;
    wait_rsp(r0 + 4, "fair_timeout");
    req_valid = '0;
    wait_idle("fair_idle");
    check("fair_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("fair_order", grant_log[k], k % 2);

    // Response backpressure.
    rsp_ready = 1'b0;
    fix_lr = 1; fix_ld = 4;
    g0 = grant_cnt; r0 = rsp_cnt;
    req_valid = 3'b001;
    wait_grant(g0, "bp_grant");
    req_valid = 3'b011;
    i = 0;
    while (!rsp_valid && i < 100) begin tick(); i++; end
    check("bp_rsp_valid_seen", int'(rsp_valid), 1);
    repeat (10) tick();
    check("bp_no_new_grant", grant_cnt, g0 + 1);
    rsp_ready = 1'b1;
    wait_rsp(r0 + 1, "bp_rsp");
    req_valid = '0;
    wait_idle("bp_idle");

    // Randomized traffic.
    use_fixed = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom_range(7, 0));
      rsp_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_idle");

    // Reset during RUN, then a requester-1-only job while the old done is still pending.
    use_fixed = 1'b1; fix_lr = 1; fix_ld = 12;
    g0 = grant_cnt;
    req_valid = 3'b001;
    wait_grant(g0, "mid_grant");
    req_valid = '0;
    i = 0;
    while (!(busy && !acc_ap_start) && i < 50) begin tick(); i++; end
    check("mid_in_run", int'(busy && !acc_ap_start), 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    ref_last    = N - 1;
    model_idle  = 1'b1;
    rsp_due     = 1'b0;
    core_killed = core_act;
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    i = 0;
    while (core_act && i < 50) begin tick(); i++; end
    repeat (2) tick();
    check("stray_done_busy", int'(busy), 0);
    check("stray_done_rsp", int'(rsp_valid), 0);
    grant_log.delete();
    fix_lr = 2; fix_ld = 6;
    g0 = grant_cnt; r0 = rsp_cnt;
    req_valid = 3'b010;
    wait_grant(g0, "post_reset_grant");
    req_valid = '0;
    check("post_reset_grant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    wait_rsp(r0 + 1, "post_reset_rsp");
    wait_idle("post_reset_idle");
    check("post_reset_cycles", last_rsp_cyc, 7);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrixmul_job_scheduler.md
# matrixmul_job_scheduler

Shares one `ap_ctrl_hs` matrixmul accelerator core between `NUM_REQ` requesters. Round-robin arbitration, drives the core's `ap_start`, tracks `ap_ready`/`ap_done`, and returns a completion response carrying the requester id and the measured job latency in cycles. Sits between the system-side job sources and the HLS-generated matrixmul top, in place of a direct `ap_start` tie-off.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default 1: width of requester id, equal to clog2(`NUM_REQ`), minimum 1.
- `CNT_W`, default 16: latency counter width.

Ports:
- `ap_clk` in 1: single clock; all logic on the rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester job request, level, held until accepted.
- `req_ready` out `NUM_REQ`: one-hot accept pulse; a request is accepted in the cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `acc_ap_start` out 1: to core `ap_start`.
- `acc_ap_ready` in 1: core `ap_ready`, meaning inputs consumed.
- `acc_ap_done` in 1: core `ap_done`, a one-cycle pulse.
- `rsp_valid` out 1: completion response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out `ID_W`: requester that owned the finished job.
- `rsp_cycles` out `CNT_W`: job latency, saturating.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, START, RUN and RESP.
- IDLE:
  - If any `req_valid` is high, grant exactly one requester by round-robin. Search starts at `last_grant+1` modulo `NUM_REQ`; `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
  - Pulse `req_ready[g]` for one cycle and latch `owner=g`.
  - Clear `cnt`, go to START.
- START:
  - `acc_ap_start=1`; `cnt` increments.
  - On `acc_ap_ready=1`, drop `acc_ap_start` next cycle.
  - If `acc_ap_done` is also high in the same cycle, go to RESP; otherwise go to RUN.
  - If `acc_ap_done=1` arrives without `acc_ap_ready`, the core is treated as ready. Go to RESP; this is a protocol violation tolerated for robustness.
- RUN:
  - `acc_ap_start=0`; `cnt` increments.
  - On `acc_ap_done=1`, go to RESP.
- RESP:
  - `rsp_valid=1`, `rsp_id=owner`, `rsp_cycles=cnt`, all held stable until `rsp_valid && rsp_ready`; then go to IDLE.
  - `cnt` is frozen in this state.
- Latency counting:
  - `cnt` counts every cycle from the first START cycle through the `acc_ap_done` cycle, inclusive.
  - It saturates at 2^`CNT_W`-1 and never wraps.
- Requests:
  - Requests arriving while not in IDLE wait; there is no queueing beyond the `req_valid` level.
  - A requester dropping `req_valid` before being granted is not an error.
- `acc_ap_done` in IDLE or RESP is ignored; it does not count and does not change state.

## Timing
- Reset values:
  - `req_ready=0`, `acc_ap_start=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_cycles=0`, `busy=0`.
  - State is IDLE and `last_grant=NUM_REQ-1`.
- All outputs are registered, except `req_ready`, which is decoded from the IDLE state and the registered grant.
- Grant latency: `req_valid` seen high in IDLE at cycle T gives `req_ready` in cycle T and `acc_ap_start` at T+1.
- With a core whose `ap_ready` and `ap_done` arrive L cycles after the start edge (`ap_start` high at cycle S, done at S+L), `rsp_cycles=L+1`.
- `rsp_valid` rises the cycle after `acc_ap_done`.
- Back-to-back jobs: if the response handshake completes at cycle R, the earliest next `req_ready` is at R+1 (IDLE), and the next `acc_ap_start` is at R+2.
- Mid-operation reset:
  - `ap_rst_n` low forces all outputs to their reset values asynchronously, including while `acc_ap_start` is high.
  - The in-flight job is dropped and no response is produced.

## Test plan
- Single job: `req_valid[0]=1`, core model with `ap_ready` at start+1 and `ap_done` at start+5 -> `req_ready[0]` pulses once, `acc_ap_start` is high for 2 cycles, then `rsp_valid=1`, `rsp_id=0`, `rsp_cycles=6`.
- Fairness: `req_valid=2'b11` held for 4 jobs, `rsp_ready=1` -> grant order 0,1,0,1; each `req_ready` is a single-cycle pulse.
- Response backpressure: `rsp_ready=0` for 10 cycles after done -> `rsp_valid`, `rsp_id` and `rsp_cycles` are held constant; no new grant and no `acc_ap_start` until the handshake completes.
- Same-cycle ready/done: core asserts `ap_ready` and `ap_done` together 3 cycles after start -> FSM goes START→RESP with `rsp_cycles=4` and never enters RUN.
- Saturation: `CNT_W=4`, `ap_done` at 40 cycles -> `rsp_cycles=15`.
- Reset mid-job: deassert `ap_rst_n` while in RUN -> `acc_ap_start=0`, `busy=0`, `rsp_valid=0` immediately. After release, a `req_valid[1]`-only request is granted (`last_grant` was reset), and the stray `ap_done` that follows from the old job is ignored in IDLE.
